// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit bus computer control sequencer.
// Holds opcode encodings, control-word bit positions, the control-word type
// and the microstep counter width.
package eater_pkg;

  localparam int STEP_W = 3;

  typedef logic [15:0] ctrl_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int C_HLT = 15;
  localparam int C_MI  = 14;
  localparam int C_RI  = 13;
  localparam int C_RO  = 12;
  localparam int C_IO  = 11;
  localparam int C_II  = 10;
  localparam int C_AI  = 9;
  localparam int C_AO  = 8;
  localparam int C_EO  = 7;
  localparam int C_SU  = 6;
  localparam int C_BI  = 5;
  localparam int C_OI  = 4;
  localparam int C_CE  = 3;
  localparam int C_CO  = 2;
  localparam int C_J   = 1;
  localparam int C_FI  = 0;

  // One-hot control word with only the given bit set.
  function automatic ctrl_t cbit(input int idx);
    return ctrl_t'(1) << idx;
  endfunction

endpackage

// File: rtl/eater_ucode_rom.sv
// Combinational microcode ROM.
// Ports:
//   opcode  - instruction opcode (upper IR nibble)
//   step    - microstep to look up (T0..T4; 5..7 decode to all-zero)
//   flag_c  - carry flag, selects JC taken/not taken
//   flag_z  - zero flag, selects JZ taken/not taken
//   ctrl    - control word for that (opcode, step, flags)
module eater_ucode_rom
  import eater_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              flag_c,
  input  logic              flag_z,
  output ctrl_t             ctrl
);

  always_comb begin
    ctrl = '0;
    case (step)
      3'd0: ctrl = cbit(C_CO) | cbit(C_MI);
      3'd1: ctrl = cbit(C_RO) | cbit(C_II) | cbit(C_CE);
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = cbit(C_IO) | cbit(C_MI);
          OP_LDI: ctrl = cbit(C_IO) | cbit(C_AI);
          OP_JMP: ctrl = cbit(C_IO) | cbit(C_J);
          OP_JC:  ctrl = flag_c ? (cbit(C_IO) | cbit(C_J)) : '0;
          OP_JZ:  ctrl = flag_z ? (cbit(C_IO) | cbit(C_J)) : '0;
          OP_OUT: ctrl = cbit(C_AO) | cbit(C_OI);
          OP_HLT: ctrl = cbit(C_HLT);
          default: ctrl = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         ctrl = cbit(C_RO) | cbit(C_AI);
          OP_ADD, OP_SUB: ctrl = cbit(C_RO) | cbit(C_BI);
          OP_STA:         ctrl = cbit(C_AO) | cbit(C_RI);
          default:        ctrl = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:  ctrl = cbit(C_EO) | cbit(C_AI) | cbit(C_FI);
          OP_SUB:  ctrl = cbit(C_EO) | cbit(C_AI) | cbit(C_SU) | cbit(C_FI);
          default: ctrl = '0;
        endcase
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/eater_control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus computer.
// Ports:
//   clk     - system clock; bus stages latch on rising edge, sequencer
//             advances on the falling edge
//   clr     - asynchronous active-high reset
//   opcode  - upper nibble of the instruction register
//   flag_c  - registered carry flag
//   flag_z  - registered zero flag
//   ctrl    - 16-bit control word (combinational, forced to HLT when halted)
//   step    - current microstep
//   halted  - sticky halt indicator, cleared only by clr
//
// state      | meaning
// step 0..4  | running, fetch (T0,T1) then execute (T2..T4)
// halted=1   | HLT executed at T2; step frozen at 2, ctrl = HLT only
module eater_control_sequencer
  import eater_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output ctrl_t             ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] HALT_STEP = STEP_W'(2);

  logic [STEP_W-1:0] step_plus;
  logic [STEP_W-1:0] step_next;
  ctrl_t             cur_ctrl;
  ctrl_t             ahead_ctrl;
  logic              halt_now;

  assign step_plus = step + STEP_W'(1);

  eater_ucode_rom u_rom_cur (
    .opcode (opcode),
    .step   (step),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (cur_ctrl)
  );

  // Lookahead at the following microstep: an empty next word ends the
  // instruction early instead of burning idle cycles.
  eater_ucode_rom u_rom_ahead (
    .opcode (opcode),
    .step   (step_plus),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ahead_ctrl)
  );

  assign halt_now = (step == HALT_STEP) && (opcode == OP_HLT);

  always_comb begin
    step_next = step_plus;
    // >= also recovers from the unreachable values 5..7.
    if (step >= LAST_STEP) begin
      step_next = '0;
    end else if ((step != '0) && (ahead_ctrl == '0)) begin
      step_next = '0;
    end
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      step   <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (halt_now) begin
        halted <= 1'b1;
      end else begin
        step <= step_next;
      end
    end
  end

  assign ctrl = halted ? cbit(C_HLT) : cur_ctrl;

endmodule

// File: tb/tb_eater_control_sequencer.sv
module tb_eater_control_sequencer;

  typedef logic [15:0] wq_t[$];

  typedef struct {
    logic       clr;
    logic [3:0] op;
    logic       c;
    logic       z;
    int         exp_step;
    logic [15:0] exp_ctrl;
    logic       exp_halted;
  } vec_t;

  logic        clk;
  logic        clr;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int checks = 0;
  int errors = 0;

  int   m_pos;
  logic m_halted;

  eater_control_sequencer #(.STEPS(5)) dut (
    .clk    (clk),
    .clr    (clr),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .step   (step),
    .halted (halted)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Whole microprogram of one instruction; its length is the cycle count.
  function automatic wq_t program_of(input logic [3:0] op, input logic c, input logic z);
    wq_t p;
    p = '{16'h4004, 16'h1408};
    case (op)
      4'h1: p = '{16'h4004, 16'h1408, 16'h4800, 16'h1200};
      4'h2: p = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281};
      4'h3: p = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1};
      4'h4: p = '{16'h4004, 16'h1408, 16'h4800, 16'h2100};
      4'h5: p = '{16'h4004, 16'h1408, 16'h0A00};
      4'h6: p = '{16'h4004, 16'h1408, 16'h0802};
      4'h7: if (c) p = '{16'h4004, 16'h1408, 16'h0802};
      4'h8: if (z) p = '{16'h4004, 16'h1408, 16'h0802};
      4'hE: p = '{16'h4004, 16'h1408, 16'h0110};
      4'hF: p = '{16'h4004, 16'h1408, 16'h8000};
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [15:0] model_ctrl();
    wq_t p;
    if (m_halted) return 16'h8000;
    p = program_of(opcode, flag_c, flag_z);
    if (m_pos < p.size()) return p[m_pos];
    return 16'h0000;
  endfunction

  task automatic model_edge();
    wq_t p;
    if (clr) begin
      m_pos = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      p = program_of(opcode, flag_c, flag_z);
      if (m_pos == 2 && opcode == 4'hF) m_halted = 1'b1;
      else if (m_pos + 1 < p.size()) m_pos = m_pos + 1;
      else m_pos = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input int es, input logic [15:0] ec, input logic eh);
    chk({name, ".step"}, 32'(step), 32'(es));
    chk({name, ".ctrl"}, 32'(ctrl), 32'(ec));
    chk({name, ".halted"}, 32'(halted), 32'(eh));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    clr = 1'b1;
    opcode = 4'h2;
    flag_c = 1'b0;
    flag_z = 1'b0;

    // clr, op, c, z, step, ctrl, halted
    vecs.push_back('{1'b1, 4'h2, 1'b0, 1'b0, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 2, 16'h4800, 1'b0});
    vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 3, 16'h1020, 1'b0});
    vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 4, 16'h0281, 1'b0});
    vecs.push_back('{1'b0, 4'h7, 1'b0, 1'b0, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h7, 1'b0, 1'b0, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h7, 1'b1, 1'b0, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h7, 1'b1, 1'b0, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h7, 1'b1, 1'b0, 2, 16'h0802, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h5, 1'b0, 1'b0, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h5, 1'b0, 1'b0, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h5, 1'b0, 1'b0, 2, 16'h0A00, 1'b0});
    vecs.push_back('{1'b0, 4'h3, 1'b0, 1'b1, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h3, 1'b0, 1'b1, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h3, 1'b0, 1'b1, 2, 16'h4800, 1'b0});
    vecs.push_back('{1'b0, 4'h3, 1'b0, 1'b1, 3, 16'h1020, 1'b0});
    vecs.push_back('{1'b0, 4'h3, 1'b0, 1'b1, 4, 16'h02C1, 1'b0});
    vecs.push_back('{1'b0, 4'h8, 1'b0, 1'b1, 0, 16'h4004, 1'b0});
    vecs.push_back('{1'b0, 4'h8, 1'b0, 1'b1, 1, 16'h1408, 1'b0});
    vecs.push_back('{1'b0, 4'h8, 1'b0, 1'b1, 2, 16'h0802, 1'b0});
    vecs.push_back('{1'b0, 4'h6, 1'b0, 1'b0, 0, 16'h4004, 1'b0});

    foreach (vecs[i]) begin
      clr    = vecs[i].clr;
      opcode = vecs[i].op;
      flag_c = vecs[i].c;
      flag_z = vecs[i].z;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_step, vecs[i].exp_ctrl, vecs[i].exp_halted);
      next_cycle();
    end

    // Bring back to step 0 (JMP at step 1 now), then run HLT.
    next_cycle();
    next_cycle();
    chk_all("pre_hlt", 0, 16'h4004, 1'b0);
    opcode = 4'hF;
    next_cycle();
    next_cycle();
    chk_all("hlt_t2", 2, 16'h8000, 1'b0);
    next_cycle();
    for (int k = 0; k < 12; k++) begin
      opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      #1;
      chk_all($sformatf("halted%0d", k), 2, 16'h8000, 1'b1);
      next_cycle();
    end
    clr = 1'b1;
    #1;
    chk_all("hlt_clr", 0, 16'h4004, 1'b0);
    clr = 1'b0;
    opcode = 4'h2;
    next_cycle();
    chk_all("post_clr_t1", 1, 16'h1408, 1'b0);

    // Async clr mid-ADD at step 3, checked well away from any edge.
    next_cycle();
    next_cycle();
    chk_all("add_t3", 3, 16'h1020, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    chk_all("async_clr", 0, 16'h4004, 1'b0);
    next_cycle();
    chk_all("clr_held", 0, 16'h4004, 1'b0);
    clr = 1'b0;

    // HLT at T2 together with clr: clr wins.
    opcode = 4'hF;
    next_cycle();
    next_cycle();
    chk_all("hlt_clr_race_t2", 2, 16'h8000, 1'b0);
    clr = 1'b1;
    next_cycle();
    chk_all("hlt_clr_race", 0, 16'h4004, 1'b0);
    clr = 1'b0;

    // Randomized run against the instruction-level model.
    m_pos = 0;
    m_halted = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0)) begin
        clr = 1'b1;
        #1;
        m_pos = 0;
        m_halted = 1'b0;
        chk_all($sformatf("rnd_clr%0d", i), m_pos, model_ctrl(), m_halted);
        clr = 1'b0;
      end
      if ((m_pos == 0 && $urandom_range(0, 9) < 7) || $urandom_range(0, 19) == 0)
        opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      #1;
      chk_all($sformatf("rnd%0d", i), m_pos, model_ctrl(), m_halted);
      @(negedge clk);
      model_edge();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eater_control_sequencer.md
# eater_control_sequencer

Microcoded control sequencer for the 8-bit bus computer. It steps through the fetch and execute microsteps of each instruction. From the current opcode and ALU flags it generates the 16-bit control word that drives every bus stage. That includes the 4-bit program counter's count-enable (CE), output (CO) and load (J) lines, so the sequencer sits directly upstream of the program counter.

## Interface
Parameters:
- `STEPS`, 5: microsteps per instruction, T0..T4; the step register is 3 bits.

Ports:
- `clk` in 1: system clock. Bus stages latch on the rising edge; the sequencer advances on the falling edge.
- `clr` in 1: reset, asynchronous, active-high.
- `opcode` in 4: upper nibble of the instruction register.
- `flag_c` in 1: registered carry flag from the flags register.
- `flag_z` in 1: registered zero flag from the flags register.
- `ctrl` out 16: control word. Bit map: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- `step` out 3: current microstep, for debug LEDs.
- `halted` out 1: sticky halt indicator.

## Operation
- `ctrl` is combinational: ucode(opcode, step, flags), gated by `halted`.
- Fetch, identical for every opcode:
  - T0 = CO|MI, 0x4004
  - T1 = RO|II|CE, 0x1408
- Execute, T2..T4:
  - LDA 0001: T2 IO|MI 0x4800; T3 RO|AI 0x1200
  - ADD 0010: T2 0x4800; T3 RO|BI 0x1020; T4 EO|AI|FI 0x0281
  - SUB 0011: as ADD, but T4 = 0x02C1 (adds SU)
  - STA 0100: T2 0x4800; T3 AO|RI 0x2100
  - LDI 0101: T2 IO|AI 0x0A00
  - JMP 0110: T2 IO|J 0x0802
  - JC 0111: T2 0x0802 if `flag_c`=1, else 0x0000
  - JZ 1000: T2 0x0802 if `flag_z`=1, else 0x0000
  - OUT 1110: T2 AO|OI 0x0110
  - HLT 1111: T2 HLT 0x8000
  - NOP 0000 and all unlisted opcodes: 0x0000 at T2..T4.
- Step advance, on the falling edge of `clk`:
  - If `halted`: step holds.
  - Else if step = 4: step becomes 0.
  - Else if step ≥ 1 and ucode(opcode, step+1, flags) = 0x0000: step becomes 0 (early termination).
  - Else: step becomes step+1.
- Early termination means:
  - NOP, and JC/JZ not taken, take 2 cycles.
  - LDI, JMP, OUT take 3 cycles.
  - LDA, STA take 4 cycles.
  - ADD, SUB take 5 cycles.
- Halt:
  - At the falling edge ending a cycle with step = 2 and opcode = HLT, `halted` sets to 1 and step stays 2.
  - While `halted`: `ctrl` = 0x8000 constantly. External clock gating uses bit 15.
  - Only `clr` clears `halted`.
- Reset:
  - `clr`=1 asynchronously forces step=0 and halted=0. `ctrl` therefore becomes 0x4004.
  - Reset mid-instruction aborts that instruction. No partial microstep is replayed.
  - Releasing `clr` resumes counting at the next falling edge.

## Timing
- Reset values: `step`=0, `halted`=0, `ctrl`=0x4004.
- `ctrl` changes only after a falling edge of `clk`, or on an `opcode`/flag change. It must be settled before the next rising edge, i.e. within the low half-period.
- `opcode` is loaded by the instruction register at the T1 rising edge. The T2 decode sees the new opcode.
- Flags are sampled combinationally during T2 for JC/JZ, and for the early-termination check at the T1 falling edge.
- Decode latency 0 cycles. Step register update latency: one falling edge.
- Simultaneous HLT decode and `clr`: `clr` wins; `halted` stays 0.
- Step never reaches 5..7. If it somehow holds such a value, `ctrl`=0x0000 and the next step is 0.

## Structure
- Package `eater_pkg` holds:
  - opcode constants (OP_NOP … OP_HLT)
  - control-bit index constants (C_HLT=15 … C_FI=0)
  - `ctrl_t` 16-bit typedef
  - STEP_W=3
- Sub-module `eater_ucode_rom`: combinational, (opcode, step, flag_c, flag_z) → ctrl_t. It is instantiated twice: once for the current step, once for the step+1 lookahead.
- Top level holds the falling-edge step register, the halt latch and the output gating.

## Test plan
- Assert `clr`, then release: `ctrl`=0x4004, `step`=0. After one falling edge: `ctrl`=0x1408, `step`=1.
- `opcode`=0010 (ADD), flags 0: sequence over 5 cycles is 0x4004, 0x1408, 0x4800, 0x1020, 0x0281, then `step` returns to 0.
- `opcode`=0111 (JC), `flag_c`=0: 2 cycles, 0x4004, 0x1408, then back to step 0. With `flag_c`=1: 3 cycles ending 0x0802.
- `opcode`=0000 (NOP), then 0101 (LDI): NOP takes 2 cycles; LDI gives T2 = 0x0A00 and wraps to step 0 after 3 cycles.
- `opcode`=1111 (HLT): after T2, `halted`=1 and `ctrl`=0x8000 held for 10+ clocks with `step`=2. Pulsing `clr` gives `halted`=0 and `ctrl`=0x4004.
- Assert `clr` during ADD at step 3: `step`=0 and `ctrl`=0x4004 immediately, with no waiting for a clock edge.
